// File: rtl/io_board_pkg.sv
// io_board_pkg: shared IO bus layout constants for the board controller and the data memory IO decode.
package io_board_pkg;
  localparam int NUM_SW       = 10;
  localparam int NUM_KEY      = 4;
  localparam int LED_LSB      = 0;
  localparam int HEX_LSB      = 10;
  localparam int HEX_WIDTH    = 7;
  localparam int NUM_HEX      = 6;
  localparam int IO_IN_WIDTH  = 14;
  localparam int IO_OUT_WIDTH = 52;
  typedef logic [HEX_WIDTH-1:0] seg_t;
  function automatic seg_t hex_field(input logic [IO_OUT_WIDTH-1:0] bus, input int idx);
    return bus[HEX_LSB + idx*HEX_WIDTH +: HEX_WIDTH];
  endfunction
endpackage

// File: rtl/io_debounce.sv
// io_debounce: two-flop synchronizer plus counting debouncer for one asynchronous pin.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin_i,
  output logic stable_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic meta_q, sync_q, stable_q, stable_d, level;
  logic [CW-1:0] cnt_q, cnt_d;
  // The idle pin level maps to 0, so active-low pins come out as 1 = pressed.
  assign level = sync_q ^ RESET_VALUE;
  always_comb begin
    stable_d = (level != stable_q && cnt_q == LAST) ? level : stable_q;
    cnt_d = (level == stable_q || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q   <= RESET_VALUE;
      sync_q   <= RESET_VALUE;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= pin_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
  assign stable_o = stable_q;
endmodule

// File: rtl/io_board_controller.sv
// io_board_controller: debounced switch/button inputs and registered LED/seven-segment outputs.
module io_board_controller import io_board_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit HEX_ACTIVE_LOW = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_SW-1:0]       sw_in,
  input  logic [NUM_KEY-1:0]      key_n_in,
  output logic [IO_IN_WIDTH-1:0]  io_input_bus,
  input  logic [IO_OUT_WIDTH-1:0] io_output_bus,
  output logic [NUM_SW-1:0]       ledr,
  output logic [HEX_WIDTH-1:0]    hex0,
  output logic [HEX_WIDTH-1:0]    hex1,
  output logic [HEX_WIDTH-1:0]    hex2,
  output logic [HEX_WIDTH-1:0]    hex3,
  output logic [HEX_WIDTH-1:0]    hex4,
  output logic [HEX_WIDTH-1:0]    hex5
);
  localparam seg_t HEX_XOR = {HEX_WIDTH{HEX_ACTIVE_LOW}};
  logic [NUM_SW-1:0] ledr_q, ledr_d;
  seg_t hex_q [NUM_HEX];
  seg_t hex_d [NUM_HEX];
  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(1'b0)) u_db (
      .clock(clock), .reset(reset), .pin_i(sw_in[i]), .stable_o(io_input_bus[i])
    );
  end
  for (genvar i = 0; i < NUM_KEY; i++) begin : g_key
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VALUE(1'b1)) u_db (
      .clock(clock), .reset(reset), .pin_i(key_n_in[i]), .stable_o(io_input_bus[NUM_SW+i])
    );
  end
  always_comb begin
    ledr_d = io_output_bus[LED_LSB +: NUM_SW];
    for (int n = 0; n < NUM_HEX; n++) hex_d[n] = hex_field(io_output_bus, n) ^ HEX_XOR;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      ledr_q <= '0;
      for (int n = 0; n < NUM_HEX; n++) hex_q[n] <= HEX_XOR;
    end else begin
      ledr_q <= ledr_d;
      for (int n = 0; n < NUM_HEX; n++) hex_q[n] <= hex_d[n];
    end
  end
  assign ledr = ledr_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
endmodule

// File: tb/tb_io_board_controller.sv
// tb_io_board_controller: directed checks of debounce latency, glitch rejection, reset and output mapping.
module tb_io_board_controller;
  logic clock = 1'b0;
  logic reset;
  logic [9:0] sw_in;
  logic [3:0] key_n_in;
  logic [13:0] io_input_bus;
  logic [51:0] io_output_bus;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  int total = 0;
  int fails = 0;
  always #5 clock = ~clock;
  io_board_controller #(.DEBOUNCE_CYCLES(4), .HEX_ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .sw_in(sw_in), .key_n_in(key_n_in),
    .io_input_bus(io_input_bus), .io_output_bus(io_output_bus), .ledr(ledr),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_hex(input string tag, input logic [6:0] e0, input logic [6:0] e5);
    chk({tag, "_hex0"}, {25'd0, hex0}, {25'd0, e0});
    chk({tag, "_hex1"}, {25'd0, hex1}, 32'h7F);
    chk({tag, "_hex2"}, {25'd0, hex2}, 32'h7F);
    chk({tag, "_hex3"}, {25'd0, hex3}, 32'h7F);
    chk({tag, "_hex4"}, {25'd0, hex4}, 32'h7F);
    chk({tag, "_hex5"}, {25'd0, hex5}, {25'd0, e5});
  endtask
  initial begin
    reset = 1'b1;
    sw_in = '0;
    key_n_in = 4'hF;
    io_output_bus = '0;
    step();
    step();
    chk("rst_in", {18'd0, io_input_bus}, 32'h0);
    chk("rst_ledr", {22'd0, ledr}, 32'h0);
    chk_hex("rst", 7'h7F, 7'h7F);
    reset = 1'b0;
    repeat (3) step();
    chk("idle_in", {18'd0, io_input_bus}, 32'h0);
    chk_hex("idle", 7'h7F, 7'h7F);
    sw_in[3] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk($sformatf("sw3_step%0d", n), {18'd0, io_input_bus}, (n >= 6) ? 32'h8 : 32'h0);
    end
    sw_in[0] = 1'b1;
    repeat (3) step();
    sw_in[0] = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      step();
      chk($sformatf("glitch_step%0d", n), {18'd0, io_input_bus}, 32'h8);
    end
    sw_in[0] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk($sformatf("sw0_step%0d", n), {18'd0, io_input_bus}, (n >= 6) ? 32'h9 : 32'h8);
    end
    key_n_in[2] = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk($sformatf("key2_press%0d", n), {31'd0, io_input_bus[12]}, (n >= 6) ? 32'h1 : 32'h0);
    end
    key_n_in[2] = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      chk($sformatf("key2_release%0d", n), {31'd0, io_input_bus[12]}, (n >= 6) ? 32'h0 : 32'h1);
    end
    io_output_bus = '0;
    io_output_bus[16:10] = 7'b0111111;
    io_output_bus[9:0] = 10'h2A5;
    chk("out_before_ledr", {22'd0, ledr}, 32'h0);
    step();
    chk("out_ledr", {22'd0, ledr}, 32'h2A5);
    chk_hex("out", 7'b1000000, 7'h7F);
    io_output_bus[51:45] = 7'h55;
    step();
    chk_hex("out5", 7'b1000000, 7'h2A);
    sw_in = 10'h020;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_in", {18'd0, io_input_bus}, 32'h0);
    chk("rst_mid_ledr", {22'd0, ledr}, 32'h0);
    for (int n = 1; n <= 6; n++) begin
      step();
      chk($sformatf("sw5_after_rst%0d", n), {18'd0, io_input_bus}, (n >= 6) ? 32'h20 : 32'h0);
    end
    chk("ledr_after_rst", {22'd0, ledr}, 32'h2A5);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
